// File: rtl/pipelined_array_mult.sv
// Pipelined array multiplier, unsigned or two's-complement per transaction.
// Partial-product rows are accumulated across STAGES registered stages.
module pipelined_array_mult #(
   parameter int WIDTH          = 4,
   parameter int ROWS_PER_STAGE = 1
) (
   input  logic                 clk,
   input  logic                 rst_n,
   input  logic                 in_valid,
   output logic                 in_ready,
   input  logic [WIDTH-1:0]     in_a,
   input  logic [WIDTH-1:0]     in_b,
   input  logic                 in_signed,
   output logic                 out_valid,
   input  logic                 out_ready,
   output logic [2*WIDTH-1:0]   out_product,
   output logic                 out_signed
);

   localparam int STAGES = WIDTH / ROWS_PER_STAGE;
   localparam int PW     = 2 * WIDTH;

   if (WIDTH < 2 || WIDTH > 16 || (WIDTH % ROWS_PER_STAGE) != 0) begin : g_bad_cfg
      $error("pipelined_array_mult: illegal WIDTH/ROWS_PER_STAGE");
   end

   logic advance;

   for (genvar s = 0; s < STAGES; s++) begin : g_stage
      logic [WIDTH-1:0] a_i;
      logic [WIDTH-1:0] b_i;
      logic             sg_i;
      logic             v_i;
      logic [PW-1:0]    sum_i;
      logic [PW-1:0]    a_ext;
      logic [PW-1:0]    sum_d;

      logic [WIDTH-1:0] a_q;
      logic [WIDTH-1:0] b_q;
      logic             sg_q;
      logic             v_q;
      logic [PW-1:0]    sum_q;

      if (s == 0) begin : g_first
         assign a_i   = in_a;
         assign b_i   = in_b;
         assign sg_i  = in_signed;
         assign v_i   = in_valid;
         assign sum_i = '0;
      end else begin : g_next
         assign a_i   = g_stage[s-1].a_q;
         assign b_i   = g_stage[s-1].b_q;
         assign sg_i  = g_stage[s-1].sg_q;
         assign v_i   = g_stage[s-1].v_q;
         assign sum_i = g_stage[s-1].sum_q;
      end

      assign a_ext = {{WIDTH{sg_i & a_i[WIDTH-1]}}, a_i};

      // Signed mode: multiplier MSB carries weight -2^(W-1), so its row subtracts.
      always_comb begin
         sum_d = sum_i;
         for (int r = 0; r < ROWS_PER_STAGE; r++) begin
            if (b_i[s*ROWS_PER_STAGE + r]) begin
               if (sg_i && (s*ROWS_PER_STAGE + r == WIDTH - 1)) begin
                  sum_d = sum_d - (a_ext << (s*ROWS_PER_STAGE + r));
               end else begin
                  sum_d = sum_d + (a_ext << (s*ROWS_PER_STAGE + r));
               end
            end
         end
      end

      always_ff @(posedge clk or negedge rst_n) begin
         if (!rst_n) begin
            a_q   <= '0;
            b_q   <= '0;
            sg_q  <= 1'b0;
            v_q   <= 1'b0;
            sum_q <= '0;
         end else if (advance) begin
            a_q   <= a_i;
            b_q   <= b_i;
            sg_q  <= sg_i;
            v_q   <= v_i;
            sum_q <= sum_d;
         end
      end
   end

   assign out_valid   = g_stage[STAGES-1].v_q;
   assign out_product = g_stage[STAGES-1].sum_q;
   assign out_signed  = g_stage[STAGES-1].sg_q;

   assign advance  = !out_valid || out_ready;
   assign in_ready = advance;

   logic unused_tail;
   assign unused_tail = ^{g_stage[STAGES-1].a_q, g_stage[STAGES-1].b_q};

endmodule

// File: tb/tb_pipelined_array_mult.sv
// Bench for pipelined_array_mult: WIDTH=4/RPS=1 and WIDTH=8/RPS=2 lanes
// checked against an integer-arithmetic scoreboard.
module tb_pipelined_array_mult;

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   always #5 clk = ~clk;

   logic [15:0] drv_a [2];
   logic [15:0] drv_b [2];
   logic        drv_v [2];
   logic        drv_s [2];
   logic        drv_r [2];
   logic [31:0] obs_p [2];
   logic        obs_v [2];
   logic        obs_s [2];
   logic        obs_rdy [2];

   bit bp_en = 1'b0;
   int n_checks = 0;
   int n_errors = 0;

   typedef struct {
      logic [31:0] p;
      logic        s;
      int          acc;
      int          stl;
   } exp_t;

   task automatic check(input string tag, input logic [31:0] got,
                        input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
      end
   endtask

   function automatic logic [31:0] ref_mult(input int w, input logic [15:0] a,
                                            input logic [15:0] b, input logic s);
      longint ax, bx, p, m;
      m  = (longint'(1) << w) - 1;
      ax = longint'(a) & m;
      bx = longint'(b) & m;
      if (s && a[w-1]) ax = ax - (longint'(1) << w);
      if (s && b[w-1]) bx = bx - (longint'(1) << w);
      p = ax * bx;
      return 32'(p & ((longint'(1) << (2*w)) - 1));
   endfunction

   for (genvar g = 0; g < 2; g++) begin : g_lane
      localparam int W  = (g == 0) ? 4 : 8;
      localparam int R  = (g == 0) ? 1 : 2;
      localparam int ST = W / R;

      logic           ir, ov, os;
      logic [2*W-1:0] op;

      pipelined_array_mult #(.WIDTH(W), .ROWS_PER_STAGE(R)) u_dut (
         .clk         (clk),
         .rst_n       (rst_n),
         .in_valid    (drv_v[g]),
         .in_ready    (ir),
         .in_a        (drv_a[g][W-1:0]),
         .in_b        (drv_b[g][W-1:0]),
         .in_signed   (drv_s[g]),
         .out_valid   (ov),
         .out_ready   (drv_r[g]),
         .out_product (op),
         .out_signed  (os)
      );

      assign obs_p[g]   = 32'(op);
      assign obs_v[g]   = ov;
      assign obs_s[g]   = os;
      assign obs_rdy[g] = ir;

      exp_t q[$];
      int   cyc = 0;
      int   stl = 0;
      bit   head_seen = 1'b0;

      always @(negedge clk) begin
         exp_t e;
         cyc++;
         if (!rst_n) begin
            q.delete();
            head_seen = 1'b0;
         end else begin
            check("in_ready", 32'(obs_rdy[g]), 32'(!obs_v[g] || drv_r[g]));
            if (q.size() == 0) begin
               check("spurious_valid", 32'(obs_v[g]), 32'(0));
            end else if (obs_v[g]) begin
               if (!head_seen) begin
                  check("latency", 32'(cyc - q[0].acc), 32'(ST + stl - q[0].stl));
                  head_seen = 1'b1;
               end
               check("product", obs_p[g], q[0].p);
               check("out_signed", 32'(obs_s[g]), 32'(q[0].s));
               if (drv_r[g]) begin
                  void'(q.pop_front());
                  head_seen = 1'b0;
               end
            end
            if (obs_v[g] && !drv_r[g]) stl++;
            if (drv_v[g] && obs_rdy[g]) begin
               e.p   = ref_mult(W, drv_a[g], drv_b[g], drv_s[g]);
               e.s   = drv_s[g];
               e.acc = cyc;
               e.stl = stl;
               q.push_back(e);
            end
         end
      end
   end

   always @(posedge clk) begin
      #1;
      for (int l = 0; l < 2; l++) drv_r[l] = bp_en ? 1'($urandom_range(0, 1)) : 1'b1;
   end

   task automatic issue(input int l, input logic [15:0] a, input logic [15:0] b,
                        input logic s);
      drv_a[l] = a;
      drv_b[l] = b;
      drv_s[l] = s;
      drv_v[l] = 1'b1;
      for (int t = 0; t < 200; t++) begin
         @(negedge clk);
         if (obs_rdy[l]) begin
            @(posedge clk);
            #1;
            drv_v[l] = 1'b0;
            return;
         end
      end
      check("issue_timeout", 32'(0), 32'(1));
      drv_v[l] = 1'b0;
   endtask

   task automatic drain();
      bp_en = 1'b0;
      for (int t = 0; t < 400; t++) begin
         @(negedge clk);
         if (g_lane[0].q.size() == 0 && g_lane[1].q.size() == 0) begin
            @(posedge clk);
            #1;
            return;
         end
      end
      check("drain_timeout", 32'(0), 32'(1));
   endtask

   initial begin
      #400000;
      $display("FAIL watchdog timeout");
      $fatal(1, "watchdog");
   end

   initial begin
      for (int l = 0; l < 2; l++) begin
         drv_a[l] = '0;
         drv_b[l] = '0;
         drv_v[l] = 1'b0;
         drv_s[l] = 1'b0;
      end
      repeat (3) @(posedge clk);
      #1;
      for (int l = 0; l < 2; l++) begin
         check("reset_valid", 32'(obs_v[l]), 32'(0));
         check("reset_product", obs_p[l], 32'(0));
         check("reset_ready", 32'(obs_rdy[l]), 32'(1));
      end
      #1 rst_n = 1'b1;
      repeat (10) @(posedge clk);
      #1;
      check("idle_product", obs_p[0], 32'(0));

      // unsigned max and signed corners, back-to-back
      issue(0, 16'd15, 16'd15, 1'b0);
      drain();
      issue(0, 16'h8, 16'h8, 1'b1);
      issue(0, 16'h8, 16'h7, 1'b1);
      issue(0, 16'hF, 16'h1, 1'b1);
      issue(0, 16'h7, 16'h7, 1'b1);
      drain();

      // backpressure stream with random gaps
      bp_en = 1'b1;
      for (int i = 0; i < 48; i++) begin
         if ($urandom_range(0, 3) == 0) begin
            @(posedge clk);
            #1;
         end
         issue(0, 16'(i % 16), 16'd3, 1'b0);
      end
      drain();

      // asynchronous reset with results in flight
      issue(0, 16'd5, 16'd6, 1'b0);
      issue(0, 16'd7, 16'd9, 1'b1);
      issue(0, 16'd11, 16'd13, 1'b0);
      @(posedge clk);
      @(posedge clk);
      #3;
      check("pre_reset_valid", 32'(obs_v[0]), 32'(1));
      rst_n = 1'b0;
      #1;
      check("async_reset_valid", 32'(obs_v[0]), 32'(0));
      check("async_reset_product", obs_p[0], 32'(0));
      check("async_reset_ready", 32'(obs_rdy[0]), 32'(1));
      @(posedge clk);
      #2 rst_n = 1'b1;
      issue(0, 16'd9, 16'd13, 1'b0);
      drain();

      // WIDTH=8 corners
      issue(1, 16'hFF, 16'hFF, 1'b0);
      issue(1, 16'h80, 16'h80, 1'b1);
      issue(1, 16'h80, 16'h7F, 1'b1);
      drain();

      // random mixed-mode traffic with backpressure
      bp_en = 1'b1;
      for (int i = 0; i < 200; i++) begin
         issue(1, 16'($urandom_range(0, 255)), 16'($urandom_range(0, 255)),
               1'($urandom_range(0, 1)));
         issue(0, 16'($urandom_range(0, 15)), 16'($urandom_range(0, 15)),
               1'($urandom_range(0, 1)));
      end
      drain();
      repeat (5) @(posedge clk);

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
